// File: rtl/zout_store_ctrl.sv
// Output-store sequencer: streams PSU store beats while walking a TAPU index.
// Optional ZOUT_STALL_CNT_EN adds a saturating backpressure stall counter.
module zout_store_ctrl #(
    parameter int DEPTH_W      = 8,
    parameter int TAPU_DEPTH_W = 5,
    parameter int N_TAPU       = 8,
    parameter int IDX_W        = (N_TAPU > 1) ? $clog2(N_TAPU) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    zout_start,
    input  logic [DEPTH_W-1:0]      store_depth,
    input  logic [TAPU_DEPTH_W-1:0] store_tapu_depth,
    input  logic                    zout_abort,
    input  logic                    store_ready,
    output logic                    psu_store_en,
    output logic [DEPTH_W-1:0]      psu_store_addr,
    output logic [IDX_W-1:0]        tapu_store_idx,
    output logic                    zout_busy,
`ifdef ZOUT_STALL_CNT_EN
    output logic [31:0]             zout_stall_cycles,
`endif
    output logic                    zout_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        STORE = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TAPU - 1);

    state_t                  state_q, state_d;
    logic [DEPTH_W-1:0]      beat_q, beat_d;
    logic [DEPTH_W-1:0]      depth_q, depth_d;
    logic [TAPU_DEPTH_W-1:0] tcnt_q, tcnt_d;
    logic [TAPU_DEPTH_W-1:0] tdepth_q, tdepth_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            depth_q  <= '0;
            tcnt_q   <= '0;
            tdepth_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            depth_q  <= depth_d;
            tcnt_q   <= tcnt_d;
            tdepth_q <= tdepth_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        depth_d  = depth_q;
        tcnt_d   = tcnt_q;
        tdepth_d = tdepth_q;
        idx_d    = idx_q;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (zout_start) begin
                    depth_d  = store_depth;
                    tdepth_d = store_tapu_depth;
                    beat_d   = '0;
                    tcnt_d   = '0;
                    idx_d    = '0;
                    state_d  = STORE;
                end
            end
            STORE: begin
                // Abort wins over a beat accepted in the same cycle.
                if (zout_abort) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    tcnt_d  = '0;
                    idx_d   = '0;
                end else if (store_ready) begin
                    if (tcnt_q == tdepth_q) begin
                        tcnt_d = '0;
                        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                    if (beat_q == depth_q) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        beat_d  = '0;
                        tcnt_d  = '0;
                        idx_d   = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign psu_store_en   = (state_q == STORE);
    assign zout_busy      = (state_q == STORE);
    assign psu_store_addr = beat_q;
    assign tapu_store_idx = idx_q;
    assign zout_done      = done;

`ifdef ZOUT_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == IDLE && zout_start) begin
            stall_q <= '0;
        end else if (state_q == STORE && !store_ready && !(&stall_q)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign zout_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_zout_store_ctrl.sv
// Directed vector bench for zout_store_ctrl, run at N_TAPU=8 and N_TAPU=3.
// Each vector drives one cycle's inputs and checks that cycle's outputs.
module tb_zout_store_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       zout_start;
    logic [7:0] store_depth;
    logic [4:0] store_tapu_depth;
    logic       zout_abort;
    logic       store_ready;

    logic       en8, busy8, done8;
    logic [7:0] addr8;
    logic [2:0] idx8;
    logic       en3, busy3, done3;
    logic [7:0] addr3;
    logic [1:0] idx3;
`ifdef ZOUT_STALL_CNT_EN
    logic [31:0] stall8, stall3;
`endif

    zout_store_ctrl #(.N_TAPU(8)) u8 (
`ifdef ZOUT_STALL_CNT_EN
        .zout_stall_cycles(stall8),
`endif
        .clk(clk),
        .rst(rst),
        .zout_start(zout_start),
        .store_depth(store_depth),
        .store_tapu_depth(store_tapu_depth),
        .zout_abort(zout_abort),
        .store_ready(store_ready),
        .psu_store_en(en8),
        .psu_store_addr(addr8),
        .tapu_store_idx(idx8),
        .zout_busy(busy8),
        .zout_done(done8)
    );

    zout_store_ctrl #(.N_TAPU(3)) u3 (
`ifdef ZOUT_STALL_CNT_EN
        .zout_stall_cycles(stall3),
`endif
        .clk(clk),
        .rst(rst),
        .zout_start(zout_start),
        .store_depth(store_depth),
        .store_tapu_depth(store_tapu_depth),
        .zout_abort(zout_abort),
        .store_ready(store_ready),
        .psu_store_en(en3),
        .psu_store_addr(addr3),
        .tapu_store_idx(idx3),
        .zout_busy(busy3),
        .zout_done(done3)
    );

    typedef struct {
        string      nm;
        bit         rst, start, abort, ready;
        logic [7:0] depth;
        logic [4:0] tdepth;
        bit         chk;
        bit         en;
        logic [7:0] addr;
        logic [2:0] i8;
        logic [1:0] i3;
        bit         done;
        bit         chks;
        logic [31:0] stall;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    task automatic add(string nm, bit r, bit s, bit ab, bit rdy,
                       int dep, int tdep, bit c, bit en, int addr,
                       int i8, int i3, bit done);
        vec_t v;
        v.nm = nm; v.rst = r; v.start = s; v.abort = ab; v.ready = rdy;
        v.depth = 8'(dep); v.tdepth = 5'(tdep); v.chk = c; v.en = en;
        v.addr = 8'(addr); v.i8 = 3'(i8); v.i3 = 2'(i3); v.done = done;
        v.chks = 1'b0; v.stall = '0;
        vq.push_back(v);
    endtask

    task automatic idle(string nm);
        add(nm, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic want_stall(int n);
        vec_t v;
        v = vq.pop_back();
        v.chks = 1'b1;
        v.stall = 32'(n);
        vq.push_back(v);
    endtask

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, i, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; zout_start = 1'b0; zout_abort = 1'b0;
        store_ready = 1'b0; store_depth = '0; store_tapu_depth = '0;

        // reset state
        add("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rst1", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        want_stall(0);
        idle("idle0");

        // 16 beats, 4 per TAPU, ready held; config inputs changing mid-job
        add("A_start", 0, 1, 0, 1, 15, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add("A", 0, 0, 0, 1, 2, 0, 1, 1, i, i / 4, (i / 4) % 3, i == 15);
        idle("A_end");
        want_stall(0);

        // ready toggling 1,0: 16 accepts over 31 cycles, 15 stalls
        add("B_start", 0, 1, 0, 0, 15, 3, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 31; k++) begin
            int a;
            a = (k + 1) / 2;
            add("B", 0, 0, 0, (k % 2) == 0, 0, 0, 1, 1, a, a / 4,
                (a / 4) % 3, k == 30);
        end
        idle("B_end");
        want_stall(15);
        idle("B_hold");
        want_stall(15);

        // 12 beats, 2 per TAPU: N_TAPU=3 wraps 0,0,1,1,2,2,0,...
        add("C_start", 0, 1, 0, 1, 11, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++)
            add("C", 0, 0, 0, 1, 0, 0, 1, 1, i, i / 2, (i / 2) % 3, i == 11);
        idle("C_end");
        want_stall(0);

        // single-beat job; start in done cycle ignored, next cycle accepted
        add("D_start", 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add("D_done", 0, 1, 0, 1, 5, 2, 1, 1, 0, 0, 0, 1);
        add("D_restart", 0, 1, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add("D", 0, 0, 0, 1, 0, 0, 1, 1, i, i, i % 3, i == 2);
        idle("D_end");

        // abort at addr 5, then depth 3 with one beat per TAPU
        add("E_start", 0, 1, 0, 1, 15, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add("E", 0, 0, 0, 1, 0, 0, 1, 1, i, i / 4, (i / 4) % 3, 0);
        add("E_abort", 0, 0, 1, 1, 0, 0, 1, 1, 5, 1, 1, 0);
        add("E_restart", 0, 1, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add("E2", 0, 0, 0, 1, 0, 0, 1, 1, i, i, i % 3, i == 3);
        add("E_idle_abort", 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("E_end");

        // reset mid-job at addr 7
        add("F_start", 0, 1, 0, 1, 15, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            add("F", 0, 0, 0, 1, 0, 0, 1, 1, i, i / 4, (i / 4) % 3, 0);
        add("F_rst", 1, 0, 0, 1, 0, 0, 1, 1, 7, 1, 1, 0);
        add("F_after", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("F_idle");
        add("F_start2", 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            add("F2", 0, 0, 0, 1, 0, 0, 1, 1, i, i, i, i == 1);
        idle("F_end");

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst              = vq[i].rst;
            zout_start       = vq[i].start;
            zout_abort       = vq[i].abort;
            store_ready      = vq[i].ready;
            store_depth      = vq[i].depth;
            store_tapu_depth = vq[i].tdepth;
            #1;
            if (vq[i].chk) begin
                chk({vq[i].nm, ".en8"}, i, 32'(en8), 32'(vq[i].en));
                chk({vq[i].nm, ".busy8"}, i, 32'(busy8), 32'(vq[i].en));
                chk({vq[i].nm, ".done8"}, i, 32'(done8), 32'(vq[i].done));
                chk({vq[i].nm, ".addr8"}, i, 32'(addr8), 32'(vq[i].addr));
                chk({vq[i].nm, ".idx8"}, i, 32'(idx8), 32'(vq[i].i8));
                chk({vq[i].nm, ".en3"}, i, 32'(en3), 32'(vq[i].en));
                chk({vq[i].nm, ".done3"}, i, 32'(done3), 32'(vq[i].done));
                chk({vq[i].nm, ".addr3"}, i, 32'(addr3), 32'(vq[i].addr));
                chk({vq[i].nm, ".idx3"}, i, 32'(idx3), 32'(vq[i].i3));
`ifdef ZOUT_STALL_CNT_EN
                if (vq[i].chks) begin
                    chk({vq[i].nm, ".stall8"}, i, stall8, vq[i].stall);
                    chk({vq[i].nm, ".stall3"}, i, stall3, vq[i].stall);
                end
`endif
            end
        end

        @(negedge clk);
        zout_start = 1'b0;
        zout_abort = 1'b0;
        store_ready = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
